// File: rtl/axi_addr_arbiter_if.sv
`default_nettype none
//==============================================================================
// Module   : axi_addr_arbiter_if
// Brief    : Bundle of per-master request lanes and the single downstream
//            address channel seen by axi_addr_arbiter. Also defines the
//            per-request field widths (ID_BITS, LEN_BITS, SIZE_BITS,
//            BURST_BITS) shared by the arbiter and its users.
// Revision : 1.0  initial release
//==============================================================================

`ifndef ID_BITS
`define ID_BITS 4
`endif
`ifndef LEN_BITS
`define LEN_BITS 8
`endif
`ifndef SIZE_BITS
`define SIZE_BITS 3
`endif
`ifndef BURST_BITS
`define BURST_BITS 2
`endif

interface axi_addr_arbiter_if #(
   parameter int MASTERS = 4,
   parameter int WIDTH   = 22
);
   // Upstream: one request lane per master, slice i belongs to master i
   logic [MASTERS-1:0]              M_VALID;
   logic [MASTERS-1:0]              M_READY;
   logic [MASTERS*`ID_BITS-1:0]     M_ID;
   logic [MASTERS*WIDTH-1:0]        M_ADDR;
   logic [MASTERS*`LEN_BITS-1:0]    M_LEN;
   logic [MASTERS*`SIZE_BITS-1:0]   M_SIZE;
   logic [MASTERS*`BURST_BITS-1:0]  M_BURST;

   // Downstream: the granted request
   logic [MASTERS-1:0]              MASTER;
   logic [`ID_BITS-1:0]             ID;
   logic [WIDTH-1:0]                ADDR;
   logic [`LEN_BITS-1:0]            LEN;
   logic [`SIZE_BITS-1:0]           SIZE;
   logic [`BURST_BITS-1:0]          BURST;
   logic                            VALID;
   logic                            READY;

   // Environment view: drives the requests and the downstream accept
   modport master (
      output M_VALID, M_ID, M_ADDR, M_LEN, M_SIZE, M_BURST, READY,
      input  M_READY, MASTER, ID, ADDR, LEN, SIZE, BURST, VALID
   );

   // Arbiter view
   modport slave (
      input  M_VALID, M_ID, M_ADDR, M_LEN, M_SIZE, M_BURST, READY,
      output M_READY, MASTER, ID, ADDR, LEN, SIZE, BURST, VALID
   );
endinterface

`default_nettype wire

// File: rtl/axi_addr_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : axi_addr_arbiter
// Brief    : Arbitrates MASTERS address requests onto one downstream address
//            channel. Round-robin selection from a rotating pointer; the
//            winner's fields are registered and offered until accepted.
//            Optional macro AXI_ARB_PRIO0_EN gives master 0 absolute priority
//            (master-0 grants then leave the rotation pointer untouched).
// Revision : 1.0  initial release
//==============================================================================

module axi_addr_arbiter #(
   parameter int MASTERS = 4,
   parameter int WIDTH   = 22
) (
   input  wire logic          CLK,
   input  wire logic          RESET,
   axi_addr_arbiter_if.slave  bus
);

   localparam int                 c_PW      = $clog2(MASTERS);
   localparam logic [c_PW:0]      c_NUM     = MASTERS[c_PW:0];
   localparam logic [c_PW-1:0]    c_LAST    = MASTERS[c_PW-1:0] - 1;
   localparam logic [c_PW-1:0]    c_ONE     = 1;
   localparam logic [MASTERS-1:0] c_ONEHOT0 = 1;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } state_t;

   state_t                   r_state;
   state_t                   w_state_nxt;
   logic [c_PW-1:0]          r_ptr;
   logic [c_PW-1:0]          r_grant;
   logic [MASTERS-1:0]       r_master;
   logic [`ID_BITS-1:0]      r_id;
   logic [WIDTH-1:0]         r_addr;
   logic [`LEN_BITS-1:0]     r_len;
   logic [`SIZE_BITS-1:0]    r_size;
   logic [`BURST_BITS-1:0]   r_burst;

   logic                     w_found;
   logic [c_PW-1:0]          w_sel;
   logic [c_PW-1:0]          w_cand;
   logic [c_PW:0]            w_sum;
   logic                     w_capture;
   logic                     w_hs;
   logic [c_PW-1:0]          w_ptr_inc;

   // Per-master field slices as arrays so the winner can be picked by index
   logic [`ID_BITS-1:0]      w_id_arr    [MASTERS];
   logic [WIDTH-1:0]         w_addr_arr  [MASTERS];
   logic [`LEN_BITS-1:0]     w_len_arr   [MASTERS];
   logic [`SIZE_BITS-1:0]    w_size_arr  [MASTERS];
   logic [`BURST_BITS-1:0]   w_burst_arr [MASTERS];

   genvar gi;
   generate
      for (gi = 0; gi < MASTERS; gi++) begin : g_slice
         assign w_id_arr[gi]    = bus.M_ID[gi*`ID_BITS +: `ID_BITS];
         assign w_addr_arr[gi]  = bus.M_ADDR[gi*WIDTH +: WIDTH];
         assign w_len_arr[gi]   = bus.M_LEN[gi*`LEN_BITS +: `LEN_BITS];
         assign w_size_arr[gi]  = bus.M_SIZE[gi*`SIZE_BITS +: `SIZE_BITS];
         assign w_burst_arr[gi] = bus.M_BURST[gi*`BURST_BITS +: `BURST_BITS];
      end
   endgenerate

   // Winner search: first valid master at or above r_ptr, wrapping past the top
   always_comb begin
      w_found = 1'b0;
      w_sel   = '0;
      w_cand  = '0;
      w_sum   = '0;
      for (int k = 0; k < MASTERS; k++) begin
         w_sum = {1'b0, r_ptr} + k[c_PW:0];
         if (w_sum >= c_NUM) begin
            w_sum = w_sum - c_NUM;
         end
         w_cand = w_sum[c_PW-1:0];
         if (!w_found && bus.M_VALID[w_cand]) begin
            w_found = 1'b1;
            w_sel   = w_cand;
         end
      end
`ifdef AXI_ARB_PRIO0_EN
      if (bus.M_VALID[0]) begin
         w_found = 1'b1;
         w_sel   = '0;
      end
`endif
   end

   // State register
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state: grant from IDLE, return on handshake (never regrant same cycle)
   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      w_hs        = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_found) begin
               w_capture   = 1'b1;
               w_state_nxt = OFFER;
            end
         end
         OFFER: begin
            if (bus.READY) begin
               w_hs        = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign w_ptr_inc = (r_grant == c_LAST) ? '0 : r_grant + c_ONE;

   // Grant capture and pointer rotation; fields hold while idle
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_ptr    <= '0;
         r_grant  <= '0;
         r_master <= '0;
         r_id     <= '0;
         r_addr   <= '0;
         r_len    <= '0;
         r_size   <= '0;
         r_burst  <= '0;
      end else begin
         if (w_capture) begin
            r_grant  <= w_sel;
            r_master <= c_ONEHOT0 << w_sel;
            r_id     <= w_id_arr[w_sel];
            r_addr   <= w_addr_arr[w_sel];
            r_len    <= w_len_arr[w_sel];
            r_size   <= w_size_arr[w_sel];
            r_burst  <= w_burst_arr[w_sel];
         end
         if (w_hs) begin
`ifdef AXI_ARB_PRIO0_EN
            if (r_grant != '0) begin
               r_ptr <= w_ptr_inc;
            end
`else
            r_ptr <= w_ptr_inc;
`endif
         end
      end
   end

   assign bus.VALID   = (r_state == OFFER);
   assign bus.M_READY = w_hs ? r_master : '0;
   assign bus.MASTER  = r_master;
   assign bus.ID      = r_id;
   assign bus.ADDR    = r_addr;
   assign bus.LEN     = r_len;
   assign bus.SIZE    = r_size;
   assign bus.BURST   = r_burst;

endmodule

`default_nettype wire

// File: tb/tb_axi_addr_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : tb_axi_addr_arbiter
// Brief    : Self-checking bench for axi_addr_arbiter (4 masters, 22-bit addr).
//            Expected grants are queued when stimulus is applied and compared
//            by a monitor at each downstream handshake.
// Revision : 1.0  initial release
//==============================================================================

module tb_axi_addr_arbiter;

   localparam int MASTERS = 4;
   localparam int WIDTH   = 22;
   localparam int IDB     = `ID_BITS;
   localparam int LB      = `LEN_BITS;
   localparam int SB      = `SIZE_BITS;
   localparam int BB      = `BURST_BITS;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   axi_addr_arbiter_if #(.MASTERS(MASTERS), .WIDTH(WIDTH)) bus ();

   axi_addr_arbiter #(.MASTERS(MASTERS), .WIDTH(WIDTH)) dut (
      .CLK   (clk),
      .RESET (rst),
      .bus   (bus)
   );

   typedef struct {
      int               g;
      logic [IDB-1:0]   id;
      logic [WIDTH-1:0] addr;
      logic [LB-1:0]    len;
      logic [SB-1:0]    size;
      logic [BB-1:0]    burst;
   } exp_t;

   typedef struct {
      logic [3:0] mv;
      int         g_rr;
      int         g_pr;
   } vec_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_pop   = 0;
   int   cyc     = 0;
   int   last_hs = -1;
   logic spacing_en = 1'b0;

   function automatic logic [IDB-1:0] f_id(int g, int v);
      return IDB'(g * 3 + v + 1);
   endfunction
   function automatic logic [WIDTH-1:0] f_addr(int g, int v);
      return WIDTH'((g << 18) | ((v * 37 + 5) & 'h3FFFF));
   endfunction
   function automatic logic [LB-1:0] f_len(int g, int v);
      return LB'(g * 16 + v * 5 + 1);
   endfunction
   function automatic logic [SB-1:0] f_size(int g, int v);
      return SB'(g + v);
   endfunction
   function automatic logic [BB-1:0] f_burst(int g, int v);
      return BB'(g + v + 1);
   endfunction

   function automatic exp_t mk(int g, int v);
      exp_t e;
      e.g     = g;
      e.id    = f_id(g, v);
      e.addr  = f_addr(g, v);
      e.len   = f_len(g, v);
      e.size  = f_size(g, v);
      e.burst = f_burst(g, v);
      return e;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic set_fields(input int v);
      for (int i = 0; i < MASTERS; i++) begin
         bus.M_ID[i*IDB +: IDB]       = f_id(i, v);
         bus.M_ADDR[i*WIDTH +: WIDTH] = f_addr(i, v);
         bus.M_LEN[i*LB +: LB]        = f_len(i, v);
         bus.M_SIZE[i*SB +: SB]       = f_size(i, v);
         bus.M_BURST[i*BB +: BB]      = f_burst(i, v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      bus.M_VALID = '0;
      bus.READY   = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Returns one cycle after the handshake edge that completes pop number 'target'
   task automatic wait_pops(input int target, input string name);
      int k;
      k = 0;
      while (n_pop < target && k < 40) begin
         tick();
         k++;
      end
      if (n_pop < target) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s_timeout: got %0d grants expected %0d", name, n_pop, target);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard monitor: compare every downstream handshake against the queue
   always @(negedge clk) begin
      if (!rst && bus.VALID && bus.READY) begin
         if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_grant: got MASTER=%b expected no grant", bus.MASTER);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("grant_master",  64'(bus.MASTER),  64'(1) << e.g);
            check("grant_m_ready", 64'(bus.M_READY), 64'(1) << e.g);
            check("grant_id",      64'(bus.ID),      64'(e.id));
            check("grant_addr",    64'(bus.ADDR),    64'(e.addr));
            check("grant_len",     64'(bus.LEN),     64'(e.len));
            check("grant_size",    64'(bus.SIZE),    64'(e.size));
            check("grant_burst",   64'(bus.BURST),   64'(e.burst));
            if (spacing_en && last_hs >= 0) begin
               check("grant_spacing", 64'(cyc - last_hs), 64'd2);
            end
            last_hs = cyc;
         end
         n_pop++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[7];
      int   exp_b[5];
      int   exp_c[5];
      int   k;
      int   g;

      // Hand-derived grants continuing from ptr=3 after the first sequence
      vecs[0] = '{mv: 4'b0010, g_rr: 1, g_pr: 1};
      vecs[1] = '{mv: 4'b0011, g_rr: 0, g_pr: 0};
      vecs[2] = '{mv: 4'b1001, g_rr: 3, g_pr: 0};
      vecs[3] = '{mv: 4'b1000, g_rr: 3, g_pr: 3};
      vecs[4] = '{mv: 4'b0110, g_rr: 1, g_pr: 1};
      vecs[5] = '{mv: 4'b1110, g_rr: 2, g_pr: 2};
      vecs[6] = '{mv: 4'b0111, g_rr: 0, g_pr: 0};
`ifdef AXI_ARB_PRIO0_EN
      exp_b = '{0, 0, 0, 0, 0};
      exp_c = '{0, 0, 0, 0, 0};
`else
      exp_b = '{0, 1, 2, 3, 0};
      exp_c = '{0, 1, 3, 0, 1};
`endif

      bus.M_VALID = '0;
      bus.READY   = 1'b0;
      set_fields(0);
      rst = 1'b1;
      tick();
      tick();

      // Reset values while reset is held
      check("rst_valid",   64'(bus.VALID),   64'd0);
      check("rst_master",  64'(bus.MASTER),  64'd0);
      check("rst_addr",    64'(bus.ADDR),    64'd0);
      check("rst_id",      64'(bus.ID),      64'd0);
      check("rst_len",     64'(bus.LEN),     64'd0);
      check("rst_m_ready", 64'(bus.M_READY), 64'd0);
      rst = 1'b0;

      // Single request from master 2: one-cycle latency, then ptr=3
      bus.M_VALID = 4'b0100;
      bus.READY   = 1'b1;
      sb_q.push_back(mk(2, 0));
      k = 0;
      while (!bus.VALID && k < 10) begin
         tick();
         k++;
      end
      check("first_latency", 64'(k), 64'd1);
      check("first_m_ready", 64'(bus.M_READY), 64'b0100);
      wait_pops(1, "first");
      bus.M_VALID = '0;
      check("first_after_valid",   64'(bus.VALID),   64'd0);
      check("first_after_m_ready", 64'(bus.M_READY), 64'd0);

      // Table of single requests; pointer state carries from row to row
      foreach (vecs[i]) begin
`ifdef AXI_ARB_PRIO0_EN
         g = vecs[i].g_pr;
`else
         g = vecs[i].g_rr;
`endif
         set_fields(i + 1);
         bus.M_VALID = vecs[i].mv;
         bus.READY   = 1'b1;
         sb_q.push_back(mk(g, i + 1));
         wait_pops(n_pop + 1, "vec");
         bus.M_VALID = '0;
         tick();
         check("vec_idle_valid",  64'(bus.VALID),  64'd0);
         check("vec_retain_addr", 64'(bus.ADDR),   64'(f_addr(g, i + 1)));
         check("vec_retain_mst",  64'(bus.MASTER), 64'(1) << g);
      end

      // Idle with no requests and READY high: nothing offered or accepted
      bus.M_VALID = '0;
      bus.READY   = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("idle_valid",   64'(bus.VALID),   64'd0);
         check("idle_m_ready", 64'(bus.M_READY), 64'd0);
      end

      // All four requesting: grants every 2 cycles
      do_reset();
      set_fields(20);
      spacing_en  = 1'b1;
      last_hs     = -1;
      bus.M_VALID = 4'b1111;
      bus.READY   = 1'b1;
      foreach (exp_b[i]) sb_q.push_back(mk(exp_b[i], 20));
      wait_pops(n_pop + 5, "all4");
      bus.M_VALID = '0;
      spacing_en  = 1'b0;

      // Masters 0,1,3 requesting: rotation skips the idle master 2
      do_reset();
      set_fields(30);
      bus.M_VALID = 4'b1011;
      bus.READY   = 1'b1;
      foreach (exp_c[i]) sb_q.push_back(mk(exp_c[i], 30));
      wait_pops(n_pop + 5, "m1011");
      bus.M_VALID = '0;

      // Back-pressure: offer to master 1 holds while inputs change
      do_reset();
      set_fields(40);
      bus.M_VALID = 4'b0010;
      bus.READY   = 1'b0;
      tick();
      check("bp_valid_rise", 64'(bus.VALID), 64'd1);
      for (int c = 0; c < 5; c++) begin
         set_fields(41 + c);
         bus.M_VALID = 4'b1010;
         tick();
         check("bp_valid",   64'(bus.VALID),   64'd1);
         check("bp_addr",    64'(bus.ADDR),    64'(f_addr(1, 40)));
         check("bp_master",  64'(bus.MASTER),  64'b0010);
         check("bp_m_ready", 64'(bus.M_READY), 64'd0);
      end
      bus.READY = 1'b1;
      sb_q.push_back(mk(1, 40));
      sb_q.push_back(mk(3, 45));
      wait_pops(n_pop + 1, "bp_m1");
      bus.M_VALID = 4'b1000;
      wait_pops(n_pop + 1, "bp_m3");
      bus.M_VALID = '0;

      // Reset during an offer to master 2 after ptr has moved
      do_reset();
      set_fields(50);
      bus.M_VALID = 4'b0001;
      bus.READY   = 1'b1;
      sb_q.push_back(mk(0, 50));
      wait_pops(n_pop + 1, "pre_rst");
      bus.M_VALID = 4'b0100;
      bus.READY   = 1'b0;
      tick();
      check("mid_offer_master", 64'(bus.MASTER), 64'b0100);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.M_VALID = 4'b0101;
      check("mid_rst_valid",   64'(bus.VALID),   64'd0);
      check("mid_rst_master",  64'(bus.MASTER),  64'd0);
      check("mid_rst_addr",    64'(bus.ADDR),    64'd0);
      check("mid_rst_m_ready", 64'(bus.M_READY), 64'd0);
      bus.READY = 1'b1;
      sb_q.push_back(mk(0, 50));
      wait_pops(n_pop + 1, "post_rst");
      bus.M_VALID = '0;
      tick();

      check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
